core_opf: RTL and testbench

Single-lane operand-fetch stage of the TOY core. It sits between decode and EX. It drives two read ports of the architectural register file and tracks in-flight destination registers in a scoreboard. It stalls on RAW/WAW hazards, bypasses same-cycle writebacks, and hands EX a registered bundle of opcode, destination, operands and PC over a valid/ready handshake.

---
 rtl/core_opf_if.sv | 40 ++++
 rtl/core_opf.sv | 233 +++++++++++++++++++++++
 tb/tb_core_opf.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_opf_if.sv
`default_nettype none
// ============================================================================
// Module      : core_opf_if
// Description : Decode-side and EX-side handshake bundle of the operand-fetch
//               stage.
//               Decode channel : in_valid_i, in_ready_o, in_instr_i, in_pc_i
//               EX channel     : out_valid_o, out_ready_i, out_op_o, out_d_o,
//                                out_addr_o, out_pc_o, out_opa_o, out_opb_o
//               modport slave  : view of core_opf
//               modport master : view of the surrounding pipeline
// Revision    : 1.0  initial release
// ============================================================================
interface core_opf_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] in_instr_i;
  logic [7:0]  in_pc_i;

  logic        out_valid_o;
  logic        out_ready_i;
  logic [3:0]  out_op_o;
  logic [3:0]  out_d_o;
  logic [7:0]  out_addr_o;
  logic [7:0]  out_pc_o;
  logic [15:0] out_opa_o;
  logic [15:0] out_opb_o;

  modport slave (
    input  in_valid_i, in_instr_i, in_pc_i, out_ready_i,
    output in_ready_o, out_valid_o, out_op_o, out_d_o, out_addr_o,
           out_pc_o, out_opa_o, out_opb_o
  );

  modport master (
    output in_valid_i, in_instr_i, in_pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_op_o, out_d_o, out_addr_o,
           out_pc_o, out_opa_o, out_opb_o
  );
endinterface
`default_nettype wire

// File: rtl/core_opf.sv
`default_nettype none
// ============================================================================
// Module      : core_opf
// Description : Single-lane operand-fetch stage of the TOY core. Drives two
//               register-file read ports, tracks in-flight destinations in a
//               busy scoreboard, stalls on RAW/WAW hazards, bypasses
//               same-cycle writebacks and presents a registered bundle to EX.
// Ports       : clk_i          clock
//               arst_ni        asynchronous active-low reset
//               bus            decode/EX handshake bundle (slave view)
//               rf_a/b_addr_o  register-file read addresses (combinational)
//               rf_a/b_data_i  register-file read data (combinational read)
//               wb_en_i        writeback enables, one per port
//               wb_addr_i      writeback register numbers, 4 bits per port
//               wb_data_i      writeback data, 16 bits per port
// Revision    : 1.0  initial release
// ============================================================================
module core_opf #(
  parameter int WB_PORTS = 2
) (
  input  wire                     clk_i,
  input  wire                     arst_ni,
  core_opf_if.slave               bus,
  output logic [3:0]              rf_a_addr_o,
  output logic [3:0]              rf_b_addr_o,
  input  wire  [15:0]             rf_a_data_i,
  input  wire  [15:0]             rf_b_data_i,
  input  wire  [WB_PORTS-1:0]     wb_en_i,
  input  wire  [4*WB_PORTS-1:0]   wb_addr_i,
  input  wire  [16*WB_PORTS-1:0]  wb_data_i
);

  localparam logic [3:0] C_R0 = 4'd0;

  // --------------------------------------------------------------------------
  // Instruction fields
  // --------------------------------------------------------------------------
  logic [3:0] w_op;
  logic [3:0] w_d;
  logic [3:0] w_s;
  logic [3:0] w_t;
  logic [7:0] w_addr;

  assign w_op   = bus.in_instr_i[15:12];
  assign w_d    = bus.in_instr_i[11:8];
  assign w_s    = bus.in_instr_i[7:4];
  assign w_t    = bus.in_instr_i[3:0];
  assign w_addr = bus.in_instr_i[7:0];

  // --------------------------------------------------------------------------
  // Source / destination classification by opcode
  // --------------------------------------------------------------------------
  logic w_use_a;
  logic w_use_b;
  logic w_a_is_d;
  logic w_writes_d;

  always_comb begin
    w_use_a    = 1'b0;
    w_use_b    = 1'b0;
    w_a_is_d   = 1'b0;
    w_writes_d = 1'b0;
    case (w_op)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
        w_use_a    = 1'b1;
        w_use_b    = 1'b1;
        w_writes_d = 1'b1;
      end
      4'h7, 4'h8, 4'hF: begin
        w_writes_d = 1'b1;
      end
      4'h9, 4'hC, 4'hD, 4'hE: begin
        w_use_a  = 1'b1;
        w_a_is_d = 1'b1;
      end
      4'hA: begin
        w_use_b    = 1'b1;
        w_writes_d = 1'b1;
      end
      4'hB: begin
        w_use_a  = 1'b1;
        w_a_is_d = 1'b1;
        w_use_b  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Unused ports read R0 so that their operand naturally falls out as zero
  logic [3:0] w_a_src;
  logic [3:0] w_b_src;

  assign w_a_src     = w_use_a ? (w_a_is_d ? w_d : w_s) : C_R0;
  assign w_b_src     = w_use_b ? w_t : C_R0;
  assign rf_a_addr_o = w_a_src;
  assign rf_b_addr_o = w_b_src;

  // --------------------------------------------------------------------------
  // Writeback port unpacking and per-register hit vector
  // --------------------------------------------------------------------------
  logic [3:0]  w_wb_addr [WB_PORTS];
  logic [15:0] w_wb_data [WB_PORTS];

  for (genvar gj = 0; gj < WB_PORTS; gj++) begin : g_wb_unpack
    assign w_wb_addr[gj] = wb_addr_i[4*gj +: 4];
    assign w_wb_data[gj] = wb_data_i[16*gj +: 16];
  end

  logic [15:0] w_wb_hit;

  always_comb begin
    w_wb_hit = '0;
    for (int j = 0; j < WB_PORTS; j++) begin
      if (wb_en_i[j]) begin
        w_wb_hit[w_wb_addr[j]] = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Operand bypass: ascending scan so the highest matching port wins, the
  // same priority the register file applies to simultaneous writes.
  // --------------------------------------------------------------------------
  logic [15:0] w_opa;
  logic [15:0] w_opb;

  always_comb begin
    w_opa = rf_a_data_i;
    w_opb = rf_b_data_i;
    for (int j = 0; j < WB_PORTS; j++) begin
      if (wb_en_i[j] && (w_wb_addr[j] == w_a_src)) begin
        w_opa = w_wb_data[j];
      end
      if (wb_en_i[j] && (w_wb_addr[j] == w_b_src)) begin
        w_opb = w_wb_data[j];
      end
    end
    // R0 reads as zero whatever the register file or writebacks hold
    if (w_a_src == C_R0) begin
      w_opa = '0;
    end
    if (w_b_src == C_R0) begin
      w_opb = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard and hazard detection
  // --------------------------------------------------------------------------
  logic [15:0] r_busy;
  logic [15:0] w_busy_nxt;
  logic [15:0] w_eff_busy;
  logic        w_dst_live;
  logic        w_raw;
  logic        w_waw;
  logic        w_hazard;
  logic        w_in_ready;
  logic        w_accept;
  logic        r_out_valid;

  // A register being written back this cycle is already resolved
  assign w_eff_busy = r_busy & ~w_wb_hit;
  assign w_dst_live = w_writes_d & (w_d != C_R0);
  assign w_raw      = (w_use_a & w_eff_busy[w_a_src]) |
                      (w_use_b & w_eff_busy[w_b_src]);
  assign w_waw      = w_dst_live & w_eff_busy[w_d];
  assign w_hazard   = w_raw | w_waw;

  // Hazard is evaluated regardless of in_valid_i so ready never depends on it
  assign w_in_ready     = ~w_hazard & (~r_out_valid | bus.out_ready_i);
  assign w_accept       = bus.in_valid_i & w_in_ready;
  assign bus.in_ready_o = w_in_ready;

  // Set after clear: a new writer of a register being retired keeps it busy
  always_comb begin
    w_busy_nxt = r_busy & ~w_wb_hit;
    if (w_accept && w_dst_live) begin
      w_busy_nxt[w_d] = 1'b1;
    end
    w_busy_nxt[C_R0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Output bundle register
  // --------------------------------------------------------------------------
  logic [3:0]  r_out_op;
  logic [3:0]  r_out_d;
  logic [7:0]  r_out_addr;
  logic [7:0]  r_out_pc;
  logic [15:0] r_out_opa;
  logic [15:0] r_out_opb;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_out_valid <= 1'b0;
      r_out_op    <= '0;
      r_out_d     <= '0;
      r_out_addr  <= '0;
      r_out_pc    <= '0;
      r_out_opa   <= '0;
      r_out_opb   <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_op    <= w_op;
      r_out_d     <= w_d;
      r_out_addr  <= w_addr;
      r_out_pc    <= bus.in_pc_i;
      r_out_opa   <= w_opa;
      r_out_opb   <= w_opb;
    end else if (bus.out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid_o = r_out_valid;
  assign bus.out_op_o    = r_out_op;
  assign bus.out_d_o     = r_out_d;
  assign bus.out_addr_o  = r_out_addr;
  assign bus.out_pc_o    = r_out_pc;
  assign bus.out_opa_o   = r_out_opa;
  assign bus.out_opb_o   = r_out_opb;

endmodule
`default_nettype wire

// File: tb/tb_core_opf.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_opf
// Description : Self-checking bench for core_opf. Directed scenarios followed
//               by randomized traffic against a behavioural model of the
//               scoreboard, bypass and output register.
// Revision    : 1.0  initial release
// ============================================================================
module tb_core_opf;

  logic        clk;
  logic        arst_ni;
  logic [3:0]  rf_a_addr;
  logic [3:0]  rf_b_addr;
  logic [15:0] rf_a_data;
  logic [15:0] rf_b_data;
  logic [1:0]  wb_en;
  logic [7:0]  wb_addr;
  logic [31:0] wb_data;

  logic [15:0] rf [16];

  int n_vec = 0;
  int n_err = 0;

  core_opf_if bus ();

  core_opf #(.WB_PORTS(2)) dut (
    .clk_i       (clk),
    .arst_ni     (arst_ni),
    .bus         (bus),
    .rf_a_addr_o (rf_a_addr),
    .rf_b_addr_o (rf_b_addr),
    .rf_a_data_i (rf_a_data),
    .rf_b_data_i (rf_b_data),
    .wb_en_i     (wb_en),
    .wb_addr_i   (wb_addr),
    .wb_data_i   (wb_data)
  );

  // Combinational register-file read
  assign rf_a_data = rf[rf_a_addr];
  assign rf_b_data = rf[rf_b_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one edge; the register file then absorbs the writebacks that were
  // presented during the cycle (ascending, so port 1 lands last).
  task automatic tick();
    @(posedge clk);
    #1;
    for (int j = 0; j < 2; j++) begin
      if (wb_en[j]) rf[wb_addr[4*j +: 4]] = wb_data[16*j +: 16];
    end
  endtask

  task automatic idle();
    bus.in_valid_i = 1'b0;
    bus.in_instr_i = 16'h0000;
    bus.in_pc_i    = 8'h00;
    wb_en          = 2'b00;
    wb_addr        = 8'h00;
    wb_data        = 32'h0;
  endtask

  task automatic clear_reg(input logic [3:0] r);
    bus.in_valid_i = 1'b0;
    wb_en   = 2'b01;
    wb_addr = {4'h0, r};
    wb_data = {16'h0, 12'h0, r};
    tick();
    wb_en   = 2'b00;
  endtask

  // ---------------------------------------------------------------- model
  function automatic void decode(input logic [15:0] ins, output logic ua,
                                 output logic [3:0] ra, output logic ub,
                                 output logic [3:0] rb, output logic wd);
    logic [3:0] op;
    op = ins[15:12];
    ua = 1'b0; ub = 1'b0; ra = 4'h0; rb = 4'h0;
    if (op >= 4'h1 && op <= 4'h6) begin
      ua = 1'b1; ra = ins[7:4]; ub = 1'b1; rb = ins[3:0];
    end
    if (op inside {4'h9, 4'hB, 4'hC, 4'hD, 4'hE}) begin
      ua = 1'b1; ra = ins[11:8];
    end
    if (op inside {4'hA, 4'hB}) begin
      ub = 1'b1; rb = ins[3:0];
    end
    wd = (op >= 4'h1 && op <= 4'h8) || op == 4'hA || op == 4'hF;
  endfunction

  function automatic logic [15:0] fetch(input logic used, input logic [3:0] r);
    logic [15:0] v;
    if (!used || r == 4'h0) return 16'h0000;
    v = rf[r];
    for (int j = 0; j < 2; j++) begin
      if (wb_en[j] && wb_addr[4*j +: 4] == r) v = wb_data[16*j +: 16];
    end
    return v;
  endfunction

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    arst_ni = 1'b0;
    idle();
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
    rf[0] = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_hold_valid: got %b expected 0", bus.out_valid_o); end
    @(negedge clk);
    arst_ni = 1'b1;
    tick();
    n_vec++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", bus.out_valid_o); end
    n_vec++; if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b expected 1", bus.in_ready_o); end
    n_vec++; if (dut.r_busy !== 16'h0000) begin n_err++; $display("FAIL rst_busy: got %h expected 0000", dut.r_busy); end
    n_vec++; if ({bus.out_op_o, bus.out_d_o, bus.out_addr_o, bus.out_pc_o} !== 24'h0) begin n_err++; $display("FAIL rst_fields: got %h expected 000000", {bus.out_op_o, bus.out_d_o, bus.out_addr_o, bus.out_pc_o}); end
    n_vec++; if ({bus.out_opa_o, bus.out_opb_o} !== 32'h0) begin n_err++; $display("FAIL rst_operands: got %h expected 00000000", {bus.out_opa_o, bus.out_opb_o}); end
  endtask

  task automatic test_plain_issue();
    rf[1] = 16'd5;
    rf[2] = 16'd3;
    bus.in_valid_i = 1'b1; bus.in_instr_i = 16'h1312; bus.in_pc_i = 8'h10;
    #1;
    n_vec++; if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL plain_ready: got %b expected 1", bus.in_ready_o); end
    n_vec++; if ({rf_a_addr, rf_b_addr} !== 8'h12) begin n_err++; $display("FAIL plain_rf_addr: got %h expected 12", {rf_a_addr, rf_b_addr}); end
    tick();
    bus.in_valid_i = 1'b0;
    n_vec++; if (bus.out_valid_o !== 1'b1) begin n_err++; $display("FAIL plain_valid: got %b expected 1", bus.out_valid_o); end
    n_vec++; if ({bus.out_op_o, bus.out_d_o, bus.out_addr_o, bus.out_pc_o} !== 24'h131210) begin n_err++; $display("FAIL plain_fields: got %h expected 131210", {bus.out_op_o, bus.out_d_o, bus.out_addr_o, bus.out_pc_o}); end
    n_vec++; if ({bus.out_opa_o, bus.out_opb_o} !== {16'd5, 16'd3}) begin n_err++; $display("FAIL plain_operands: got %h expected 00050003", {bus.out_opa_o, bus.out_opb_o}); end
    n_vec++; if (dut.r_busy !== 16'h0008) begin n_err++; $display("FAIL plain_busy: got %h expected 0008", dut.r_busy); end
  endtask

  task automatic test_raw_bypass();
    bus.in_valid_i = 1'b1; bus.in_instr_i = 16'h2433; bus.in_pc_i = 8'h11;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_vec++; if (bus.in_ready_o !== 1'b0) begin n_err++; $display("FAIL raw_stall%0d: got %b expected 0", c, bus.in_ready_o); end
      tick();
    end
    n_vec++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL raw_drained: got %b expected 0", bus.out_valid_o); end
    wb_en = 2'b01; wb_addr = 8'h03; wb_data = 32'h0000_0008;
    #1;
    n_vec++; if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL raw_wb_ready: got %b expected 1", bus.in_ready_o); end
    tick();
    bus.in_valid_i = 1'b0; wb_en = 2'b00;
    n_vec++; if ({bus.out_valid_o, bus.out_op_o, bus.out_d_o, bus.out_pc_o} !== {1'b1, 16'h2411}) begin n_err++; $display("FAIL raw_fields: got %h expected 12411", {bus.out_valid_o, bus.out_op_o, bus.out_d_o, bus.out_pc_o}); end
    n_vec++; if ({bus.out_opa_o, bus.out_opb_o} !== 32'h0008_0008) begin n_err++; $display("FAIL raw_bypass: got %h expected 00080008", {bus.out_opa_o, bus.out_opb_o}); end
    n_vec++; if (dut.r_busy !== 16'h0010) begin n_err++; $display("FAIL raw_busy: got %h expected 0010", dut.r_busy); end
    clear_reg(4'd4);
    n_vec++; if (dut.r_busy !== 16'h0000) begin n_err++; $display("FAIL raw_clear: got %h expected 0000", dut.r_busy); end
  endtask

  task automatic test_r0();
    bus.in_valid_i = 1'b1; bus.in_instr_i = 16'h1500; bus.in_pc_i = 8'h12;
    #1;
    n_vec++; if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL r0_ready: got %b expected 1", bus.in_ready_o); end
    tick();
    n_vec++; if ({bus.out_opa_o, bus.out_opb_o} !== 32'h0) begin n_err++; $display("FAIL r0_operands: got %h expected 00000000", {bus.out_opa_o, bus.out_opb_o}); end
    n_vec++; if (dut.r_busy !== 16'h0020) begin n_err++; $display("FAIL r0_busy: got %h expected 0020", dut.r_busy); end
    bus.in_instr_i = 16'h1012; bus.in_pc_i = 8'h13;
    #1;
    n_vec++; if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL r0_dst_ready: got %b expected 1", bus.in_ready_o); end
    tick();
    bus.in_valid_i = 1'b0;
    n_vec++; if (dut.r_busy !== 16'h0020) begin n_err++; $display("FAIL r0_dst_busy: got %h expected 0020", dut.r_busy); end
    n_vec++; if ({bus.out_d_o, bus.out_opa_o, bus.out_opb_o} !== {4'h0, 16'd5, 16'd3}) begin n_err++; $display("FAIL r0_dst_bundle: got %h expected 000050003", {bus.out_d_o, bus.out_opa_o, bus.out_opb_o}); end
    clear_reg(4'd5);
  endtask

  task automatic test_dual_wb();
    bus.in_valid_i = 1'b1; bus.in_instr_i = 16'h1100; bus.in_pc_i = 8'h14;
    tick();
    n_vec++; if (dut.r_busy !== 16'h0002) begin n_err++; $display("FAIL dual_pre_busy: got %h expected 0002", dut.r_busy); end
    bus.in_instr_i = 16'h9100; bus.in_pc_i = 8'h15;
    wb_en = 2'b11; wb_addr = 8'h11; wb_data = 32'h0002_0001;
    #1;
    n_vec++; if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL dual_ready: got %b expected 1", bus.in_ready_o); end
    tick();
    bus.in_valid_i = 1'b0; wb_en = 2'b00;
    n_vec++; if ({bus.out_op_o, bus.out_opa_o, bus.out_opb_o} !== {4'h9, 16'h0002, 16'h0000}) begin n_err++; $display("FAIL dual_operands: got %h expected 900020000", {bus.out_op_o, bus.out_opa_o, bus.out_opb_o}); end
    n_vec++; if (dut.r_busy !== 16'h0000) begin n_err++; $display("FAIL dual_busy: got %h expected 0000", dut.r_busy); end
  endtask

  task automatic test_backpressure();
    logic [15:0] ea, eb;
    ea = rf[1]; eb = rf[2];
    bus.in_valid_i = 1'b1; bus.in_instr_i = 16'h1612; bus.in_pc_i = 8'h20;
    tick();
    bus.out_ready_i = 1'b0;
    bus.in_instr_i = 16'h0000; bus.in_pc_i = 8'h21;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++; if (bus.in_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_ready%0d: got %b expected 0", c, bus.in_ready_o); end
      tick();
      n_vec++; if ({bus.out_valid_o, bus.out_op_o, bus.out_d_o, bus.out_pc_o, bus.out_opa_o, bus.out_opb_o} !== {1'b1, 16'h1620, ea, eb}) begin n_err++; $display("FAIL bp_hold%0d: got %h expected %h", c, {bus.out_valid_o, bus.out_op_o, bus.out_d_o, bus.out_pc_o, bus.out_opa_o, bus.out_opb_o}, {1'b1, 16'h1620, ea, eb}); end
    end
    bus.out_ready_i = 1'b1;
    #1;
    n_vec++; if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL bp_release: got %b expected 1", bus.in_ready_o); end
    tick();
    bus.in_valid_i = 1'b0;
    n_vec++; if ({bus.out_valid_o, bus.out_op_o, bus.out_pc_o} !== {1'b1, 12'h021}) begin n_err++; $display("FAIL bp_next: got %h expected 1021", {bus.out_valid_o, bus.out_op_o, bus.out_pc_o}); end
    n_vec++; if (dut.r_busy !== 16'h0040) begin n_err++; $display("FAIL bp_busy: got %h expected 0040", dut.r_busy); end
    clear_reg(4'd6);
  endtask

  task automatic test_waw();
    bus.in_valid_i = 1'b1; bus.in_instr_i = 16'h1400; bus.in_pc_i = 8'h30;
    tick();
    bus.in_instr_i = 16'h7405; bus.in_pc_i = 8'h31;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_vec++; if (bus.in_ready_o !== 1'b0) begin n_err++; $display("FAIL waw_stall%0d: got %b expected 0", c, bus.in_ready_o); end
      tick();
    end
    wb_en = 2'b10; wb_addr = 8'h40; wb_data = 32'hABCD_0000;
    #1;
    n_vec++; if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL waw_ready: got %b expected 1", bus.in_ready_o); end
    tick();
    bus.in_valid_i = 1'b0; wb_en = 2'b00;
    n_vec++; if ({bus.out_op_o, bus.out_d_o, bus.out_addr_o, bus.out_opa_o, bus.out_opb_o} !== {16'h7405, 32'h0}) begin n_err++; $display("FAIL waw_bundle: got %h expected 740500000000", {bus.out_op_o, bus.out_d_o, bus.out_addr_o, bus.out_opa_o, bus.out_opb_o}); end
    n_vec++; if (dut.r_busy !== 16'h0010) begin n_err++; $display("FAIL waw_busy: got %h expected 0010", dut.r_busy); end
    clear_reg(4'd4);
  endtask

  task automatic test_random();
    logic [15:0] m_busy, m_opa, m_opb, ea, eb, hit, ins;
    logic        m_valid, ua, ub, wd, haz, exp_rdy, acc;
    logic [3:0]  ra, rb, m_op, m_d;
    logic [7:0]  m_addr, m_pc;
    idle();
    arst_ni = 1'b0;
    tick();
    arst_ni = 1'b1;
    m_busy = 16'h0; m_valid = 1'b0; m_op = 4'h0; m_d = 4'h0;
    m_addr = 8'h0; m_pc = 8'h0; m_opa = 16'h0; m_opb = 16'h0;
    for (int c = 0; c < 400; c++) begin
      ins = 16'($urandom);
      bus.in_valid_i  = ($urandom_range(3) != 0);
      bus.in_instr_i  = ins;
      bus.in_pc_i     = 8'($urandom);
      bus.out_ready_i = ($urandom_range(3) != 0);
      wb_en   = 2'($urandom);
      wb_addr = 8'($urandom);
      wb_data = $urandom;
      #1;
      decode(ins, ua, ra, ub, rb, wd);
      hit = 16'h0;
      for (int j = 0; j < 2; j++) if (wb_en[j]) hit[wb_addr[4*j +: 4]] = 1'b1;
      haz = (ua && m_busy[ra] && !hit[ra]) || (ub && m_busy[rb] && !hit[rb]) ||
            (wd && ins[11:8] != 4'h0 && m_busy[ins[11:8]] && !hit[ins[11:8]]);
      exp_rdy = !haz && (!m_valid || bus.out_ready_i);
      n_vec++; if (bus.in_ready_o !== exp_rdy) begin n_err++; $display("FAIL rnd_ready c=%0d ins=%h: got %b expected %b", c, ins, bus.in_ready_o, exp_rdy); end
      n_vec++; if ({rf_a_addr, rf_b_addr} !== {(ua ? ra : 4'h0), (ub ? rb : 4'h0)}) begin n_err++; $display("FAIL rnd_rf_addr c=%0d ins=%h: got %h expected %h", c, ins, {rf_a_addr, rf_b_addr}, {(ua ? ra : 4'h0), (ub ? rb : 4'h0)}); end
      ea  = fetch(ua, ra);
      eb  = fetch(ub, rb);
      acc = bus.in_valid_i && exp_rdy;
      tick();
      m_busy = m_busy & ~hit;
      if (acc && wd && ins[11:8] != 4'h0) m_busy[ins[11:8]] = 1'b1;
      if (acc) begin
        m_valid = 1'b1; m_op = ins[15:12]; m_d = ins[11:8]; m_addr = ins[7:0];
        m_pc = bus.in_pc_i; m_opa = ea; m_opb = eb;
      end else if (bus.out_ready_i) begin
        m_valid = 1'b0;
      end
      n_vec++; if ({bus.out_valid_o, bus.out_op_o, bus.out_d_o, bus.out_addr_o, bus.out_pc_o} !== {m_valid, m_op, m_d, m_addr, m_pc}) begin n_err++; $display("FAIL rnd_fields c=%0d: got %h expected %h", c, {bus.out_valid_o, bus.out_op_o, bus.out_d_o, bus.out_addr_o, bus.out_pc_o}, {m_valid, m_op, m_d, m_addr, m_pc}); end
      n_vec++; if ({bus.out_opa_o, bus.out_opb_o} !== {m_opa, m_opb}) begin n_err++; $display("FAIL rnd_operands c=%0d: got %h expected %h", c, {bus.out_opa_o, bus.out_opb_o}, {m_opa, m_opb}); end
      n_vec++; if (dut.r_busy !== m_busy) begin n_err++; $display("FAIL rnd_busy c=%0d: got %h expected %h", c, dut.r_busy, m_busy); end
    end
    idle();
    bus.out_ready_i = 1'b1;
  endtask

  task automatic test_async_reset();
    arst_ni = 1'b0;
    tick();
    arst_ni = 1'b1;
    rf[1] = 16'hBEEF;
    bus.in_valid_i = 1'b1; bus.in_instr_i = 16'h1310; bus.in_pc_i = 8'h55;
    tick();
    bus.in_valid_i = 1'b0;
    n_vec++; if ({bus.out_valid_o, bus.out_opa_o, dut.r_busy} !== {1'b1, 16'hBEEF, 16'h0008}) begin n_err++; $display("FAIL areset_pre: got %h expected %h", {bus.out_valid_o, bus.out_opa_o, dut.r_busy}, {1'b1, 16'hBEEF, 16'h0008}); end
    #2;
    arst_ni = 1'b0;
    #1;
    n_vec++; if ({bus.out_valid_o, bus.out_pc_o, bus.out_opa_o, dut.r_busy} !== 41'h0) begin n_err++; $display("FAIL areset_clear: got %h expected 0", {bus.out_valid_o, bus.out_pc_o, bus.out_opa_o, dut.r_busy}); end
    @(negedge clk);
    arst_ni = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_plain_issue();
    test_raw_bypass();
    test_r0();
    test_dual_wb();
    test_backpressure();
    test_waw();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
